// File: rtl/se_sram_arbiter_2p_pkg.sv
// se_sram_arbiter_2p_pkg: shared state/requester enums and default widths for the 2-port SRAM arbiter
package se_sram_arbiter_2p_pkg;
    typedef enum logic {CLEAR, RUN} state_t;
    typedef enum logic {A, B} req_id_t;
    localparam int DEFAULT_ADDRESS_WIDTH = 14;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_WE_WIDTH = DEFAULT_DATA_WIDTH / 8;
endpackage

// File: rtl/se_sram_arbiter_rr2.sv
// se_sram_arbiter_rr2: combinational 2-way round-robin grant with a registered last_winner
module se_sram_arbiter_rr2
    import se_sram_arbiter_2p_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic a_req,
    input  logic b_req,
    output logic a_grant,
    output logic b_grant
);
    req_id_t last_winner;
    always_comb begin
        a_grant = enable && a_req && (!b_req || last_winner == B);
        b_grant = enable && b_req && !a_grant;
    end
    always_ff @(posedge clk) begin
        if (reset) last_winner <= B;
        else if (a_grant) last_winner <= A;
        else if (b_grant) last_winner <= B;
    end
endmodule

// File: rtl/se_sram_arbiter_2p.sv
// se_sram_arbiter_2p: two-requester SRAM arbiter; SE_SRAM_ARBITER_CLEAR_EN adds a zero-fill CLEAR phase after reset
module se_sram_arbiter_2p
    import se_sram_arbiter_2p_pkg::*;
#(
    parameter int address_width = DEFAULT_ADDRESS_WIDTH,
    parameter int data_width = DEFAULT_DATA_WIDTH,
    parameter int we_width = DEFAULT_WE_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     a_req,
    input  logic                     a_read_not_write,
    input  logic [address_width-1:0] a_address,
    input  logic [data_width-1:0]    a_write_data,
    input  logic [we_width-1:0]      a_write_enable,
    output logic                     a_ack,
    output logic                     a_read_data_valid,
    input  logic                     b_req,
    input  logic                     b_read_not_write,
    input  logic [address_width-1:0] b_address,
    input  logic [data_width-1:0]    b_write_data,
    input  logic [we_width-1:0]      b_write_enable,
    output logic                     b_ack,
    output logic                     b_read_data_valid,
    output logic [data_width-1:0]    read_data,
    output logic                     sram_select,
    output logic                     sram_read_not_write,
    output logic [address_width-1:0] sram_address,
    output logic [data_width-1:0]    sram_write_data,
    output logic [we_width-1:0]      sram_write_enable,
    input  logic [data_width-1:0]    sram_data_out,
    output logic                     busy
);
    logic run, clearing, a_grant, b_grant, a_valid_q, b_valid_q;
    logic [address_width-1:0] clear_count;
`ifdef SE_SRAM_ARBITER_CLEAR_EN
    state_t state;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            clear_count <= '0;
        end else if (state == CLEAR) begin
            clear_count <= clear_count + 1'b1;
            if (&clear_count) state <= RUN;
        end
    end
    assign run = state == RUN;
    assign busy = state == CLEAR;
`else
    assign run = 1'b1;
    assign busy = 1'b0;
    assign clear_count = '0;
`endif
    assign clearing = !reset && !run;
    se_sram_arbiter_rr2 u_rr2 (
        .clk     (clk),
        .reset   (reset),
        .enable  (run && !reset),
        .a_req   (a_req),
        .b_req   (b_req),
        .a_grant (a_grant),
        .b_grant (b_grant)
    );
    always_comb begin
        sram_select = a_grant || b_grant || clearing;
        sram_read_not_write = clearing ? 1'b0 : b_grant ? b_read_not_write : a_read_not_write;
        sram_address = clearing ? clear_count : b_grant ? b_address : a_address;
        sram_write_data = clearing ? '0 : b_grant ? b_write_data : a_write_data;
        sram_write_enable = clearing ? '1 :
                            (!(a_grant || b_grant) || sram_read_not_write) ? '0 :
                            b_grant ? b_write_enable : a_write_enable;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            a_valid_q <= a_grant && a_read_not_write;
            b_valid_q <= b_grant && b_read_not_write;
        end
    end
    assign a_ack = a_grant;
    assign b_ack = b_grant;
    // a reset landing in the valid cycle must still squash the pulse
    assign a_read_data_valid = a_valid_q && !reset;
    assign b_read_data_valid = b_valid_q && !reset;
    assign read_data = sram_data_out;
endmodule
